fnd_scan_decoder: RTL and testbench
===================================

# fnd_scan_decoder

Receive-side monitor for the 4-digit multiplexed FND bus: it samples the active-low digit-select lines and active-low segment font lines that drive the display and reconstructs the four displayed hex values plus decimal points. Sits beside the display driver, in self-check logic or a capture bench, and reports each completed scan frame. It also flags bad fonts, illegal selects and a stalled scan.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit (≥2)
- TIMEOUT_CYCLES, 100000: cycles without a completed frame before o_stale (only with FND_SCAN_TIMEOUT_EN)
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_digit  input  4  digit select, active-low one-hot; bit n low = digit n lit
- i_font  input  8  segments, active-low; [6:0]=g..a, [7]=dp
- o_bcd  output  16  decoded values; digit n in [4n+3:4n]
- o_dp  output  4  decimal point per digit (1 = lit)
- o_frame_valid  output  1  one-cycle pulse: o_bcd/o_dp/o_err just updated
- o_err  output  1  error seen in the frame that produced the current o_bcd
- o_stale  output  1  no frame completed within TIMEOUT_CYCLES

## Operation
- Each edge registers {i_digit,i_font} into a sample register; a counter increments when the new sample equals the previous one, else reloads to 1.
- States: IDLE (i_digit=4'hF or illegal), QUALIFY (count < STABLE_CYCLES), HELD (captured; waits for sample change). HELD→QUALIFY or IDLE on any change.
- Capture once per dwell, on the edge where count reaches STABLE_CYCLES with exactly one i_digit bit low.
- Font map on i_font[6:0] (hex 0-F): C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (bit 7 forced 1). Unmatched code → slot value 0, frame error set.
- dp = ~i_font[7], stored per slot.
- Capture writes the shadow slot and sets seen_mask[n]. A repeated digit before frame completion overwrites its slot without error.
- Illegal select (two or more bits low) held STABLE_CYCLES samples: no capture, frame error set.
- When seen_mask becomes 4'b1111 (including the current capture):
  - o_bcd/o_dp/o_err are loaded from shadow, with the new slot included.
  - o_frame_valid pulses next cycle.
  - seen_mask and the frame error clear.
  - A frame error raised on the completing edge belongs to the completed frame.
- Digit order within a frame is irrelevant.

## Timing
- Reset: o_bcd=0, o_dp=0, o_frame_valid=0, o_err=0, o_stale=0. seen_mask, shadow, counters and sample register are cleared; state=IDLE.
- Reset is asynchronous: assertion mid-frame discards the partial frame immediately.
- Input constant from edge 0 → capture on edge STABLE_CYCLES-1 (count 1 at edge 0).
- Completing capture edge E: o_bcd/o_dp/o_err valid after E; o_frame_valid high E→E+1 only.
- Input changing on the capture edge: that capture still occurs; the next dwell restarts at count 1.
- Counter saturates at STABLE_CYCLES, so long dwells never wrap or re-capture.
- o_bcd holds between frames.

## Configuration
- FND_SCAN_TIMEOUT_EN defined:
  - A cycle counter clears on every frame completion.
  - When it reaches TIMEOUT_CYCLES, o_stale=1 and the counter saturates.
  - o_stale clears on the edge completing the next frame.
- Undefined: no counter; o_stale tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Reset held with toggling inputs → all outputs 0; o_frame_valid never pulses.
- STABLE_CYCLES=4; digits 1110,1101,1011,0111 with fonts C0,F9,A4,B0, each held 8 cycles → single o_frame_valid pulse, o_bcd=16'h3210, o_dp=0, o_err=0.
- Same scan with digit1 font 79 (dp on) and digit3 font 8E → o_bcd=16'hF210, o_dp=4'b0010.
- Digit0 font held 3 cycles, then blanked (4'hF); remaining digits valid → no frame; repeat with 4 cycles → frame completes.
- Digit2 font FF, or select 4'b1100 held 8 cycles, within an otherwise valid scan → frame completes with o_err=1 (slot2=0 for the font case); next clean frame → o_err=0.
- FND_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=20, inputs idle after reset → o_stale=1 from cycle 20; a valid scan then clears it on frame completion.

Source files
------------

// File: rtl/fnd_scan_decoder.sv
// Receive-side monitor for a 4-digit multiplexed FND bus: rebuilds the displayed hex digits and decimal points.
// Optional stalled-scan detection is enabled by defining FND_SCAN_TIMEOUT_EN.
module fnd_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_digit,
  input  logic [7:0]  i_font,
  output logic [15:0] o_bcd,
  output logic [3:0]  o_dp,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, QUALIFY, HELD} state_t;

  state_t        state_reg, state_next;
  logic [11:0]   sample_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]   shadow_reg;
  logic [3:0]    shadow_dp_reg;
  logic [3:0]    seen_reg;
  logic          frame_err_reg;
  logic [15:0]   bcd_reg;
  logic [3:0]    dp_reg;
  logic          err_reg;
  logic          frame_valid_reg;

  logic          same;
  logic          sel_blank, sel_illegal;
  logic [1:0]    sel_idx;
  logic [3:0]    font_val;
  logic          font_bad;
  logic          capture, illegal_hit;
  logic [3:0]    slot_hit;
  logic [15:0]   bcd_with;
  logic [3:0]    dp_with;
  logic [3:0]    seen_with;
  logic          frame_done;
  logic          err_now;

  assign same = ({i_digit, i_font} == sample_reg);

  always_comb begin
    sel_blank   = 1'b0;
    sel_illegal = 1'b0;
    sel_idx     = 2'd0;
    case (i_digit)
      4'b1111: sel_blank = 1'b1;
      4'b1110: sel_idx   = 2'd0;
      4'b1101: sel_idx   = 2'd1;
      4'b1011: sel_idx   = 2'd2;
      4'b0111: sel_idx   = 2'd3;
      default: sel_illegal = 1'b1;
    endcase
  end

  // Only the seven segment bits identify the glyph; dp is carried separately.
  always_comb begin
    font_val = 4'h0;
    font_bad = 1'b0;
    case (i_font[6:0])
      7'h40: font_val = 4'h0;
      7'h79: font_val = 4'h1;
      7'h24: font_val = 4'h2;
      7'h30: font_val = 4'h3;
      7'h19: font_val = 4'h4;
      7'h12: font_val = 4'h5;
      7'h02: font_val = 4'h6;
      7'h78: font_val = 4'h7;
      7'h00: font_val = 4'h8;
      7'h10: font_val = 4'h9;
      7'h08: font_val = 4'hA;
      7'h03: font_val = 4'hB;
      7'h46: font_val = 4'hC;
      7'h21: font_val = 4'hD;
      7'h06: font_val = 4'hE;
      7'h0E: font_val = 4'hF;
      default: font_bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      sample_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      sample_reg <= {i_digit, i_font};
      count_reg  <= count_next;
    end
  end

  // The run counter saturates, so a capture fires exactly once per dwell.
  always_comb begin
    count_next  = CW'(1);
    state_next  = QUALIFY;
    capture     = 1'b0;
    illegal_hit = 1'b0;
    if (same) begin
      count_next = (count_reg == STABLE_MAX) ? count_reg : count_reg + CW'(1);
    end
    if (sel_blank || sel_illegal) begin
      state_next  = IDLE;
      illegal_hit = sel_illegal && (count_next == STABLE_MAX) && (count_reg != STABLE_MAX);
    end else if (count_next == STABLE_MAX) begin
      state_next = HELD;
      capture    = (state_reg != HELD);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_hit[gi]        = capture && (sel_idx == 2'(gi));
      assign bcd_with[4*gi +: 4] = slot_hit[gi] ? font_val : shadow_reg[4*gi +: 4];
      assign dp_with[gi]         = slot_hit[gi] ? ~i_font[7] : shadow_dp_reg[gi];
    end
  endgenerate

  assign seen_with  = seen_reg | slot_hit;
  assign frame_done = capture && (seen_with == 4'hF);
  assign err_now    = (capture && font_bad) || illegal_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_reg      <= '0;
      shadow_dp_reg   <= '0;
      seen_reg        <= '0;
      frame_err_reg   <= 1'b0;
      bcd_reg         <= '0;
      dp_reg          <= '0;
      err_reg         <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      shadow_reg      <= bcd_with;
      shadow_dp_reg   <= dp_with;
      frame_valid_reg <= frame_done;
      if (frame_done) begin
        bcd_reg       <= bcd_with;
        dp_reg        <= dp_with;
        err_reg       <= frame_err_reg | err_now;
        seen_reg      <= '0;
        frame_err_reg <= 1'b0;
      end else begin
        seen_reg      <= seen_with;
        frame_err_reg <= frame_err_reg | err_now;
      end
    end
  end

`ifdef FND_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] timeout_cnt_reg;
  logic          stale_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_cnt_reg <= '0;
      stale_reg       <= 1'b0;
    end else if (frame_done) begin
      timeout_cnt_reg <= '0;
      stale_reg       <= 1'b0;
    end else if (timeout_cnt_reg != TIMEOUT_MAX) begin
      timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
      if (timeout_cnt_reg + TW'(1) == TIMEOUT_MAX) begin
        stale_reg <= 1'b1;
      end
    end
  end

  assign o_stale = stale_reg;
`else
  assign o_stale = 1'b0;
`endif

  assign o_bcd         = bcd_reg;
  assign o_dp          = dp_reg;
  assign o_err         = err_reg;
  assign o_frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: a sample-history model is checked against the DUT every cycle,
// plus literal expectations after each scenario.
module tb_fnd_scan_decoder;

  localparam int S = 4;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit;
  logic [7:0]  font;
  logic [15:0] o_bcd;
  logic [3:0]  o_dp;
  logic        o_frame_valid, o_err, o_stale;

  fnd_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digit(digit), .i_font(font),
    .o_bcd(o_bcd), .o_dp(o_dp), .o_frame_valid(o_frame_valid),
    .o_err(o_err), .o_stale(o_stale)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a history of samples; a digit is accepted when the newest S samples agree
  // and the sample before them differs (or there was none).
  logic [7:0]  lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [11:0] hist [0:S];
  int          nsamp, since, lows, pos;
  logic [3:0]  m_sh [4];
  logic [3:0]  m_shdp, m_seen, m_dp, md, mval;
  logic [7:0]  mf;
  logic [15:0] m_bcd;
  logic        m_ferr, m_err, m_fv, m_stale, run, mbad, done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nsamp = 0; since = 0;
      for (int k = 0; k < 4; k++) m_sh[k] = 4'h0;
      m_shdp = 0; m_seen = 0; m_dp = 0; m_bcd = 0;
      m_ferr = 0; m_err = 0; m_fv = 0; m_stale = 0;
    end else begin
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {digit, font};
      if (nsamp < 1000) nsamp++;
      m_fv = 0; done = 0;
      run = (nsamp >= S);
      for (int k = 1; k < S; k++) if (nsamp >= S && hist[k] != hist[0]) run = 0;
      if (run && nsamp > S && hist[S] == hist[0]) run = 0;
      if (run) begin
        md = hist[0][11:8];
        mf = hist[0][7:0];
        lows = 0; pos = 0;
        for (int j = 0; j < 4; j++) if (!md[j]) begin lows++; pos = j; end
        if (lows == 1) begin
          mval = 0; mbad = 1;
          for (int j = 0; j < 16; j++) if (lut[j][6:0] == mf[6:0]) begin mval = 4'(j); mbad = 0; end
          m_sh[pos] = mval;
          m_shdp[pos] = ~mf[7];
          m_seen[pos] = 1'b1;
          m_ferr = m_ferr | mbad;
          if (m_seen == 4'hF) begin
            m_bcd = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            m_dp = m_shdp; m_err = m_ferr; m_fv = 1;
            m_seen = 0; m_ferr = 0; done = 1;
          end
        end else if (lows >= 2) begin
          m_ferr = 1;
        end
      end
      if (done) since = 0;
      else if (since < 1000000) since++;
`ifdef FND_SCAN_TIMEOUT_EN
      m_stale = (since >= T);
`else
      m_stale = 0;
`endif
    end
  end

  // Cycle compare, sampled well after the rising edge and before inputs move on the falling edge.
  always begin
    @(posedge clk);
    #3;
    chk("bcd", 32'(o_bcd), 32'(m_bcd));
    chk("dp", 32'(o_dp), 32'(m_dp));
    chk("err", 32'(o_err), 32'(m_err));
    chk("frame_valid", 32'(o_frame_valid), 32'(m_fv));
    chk("stale", 32'(o_stale), 32'(m_stale));
    if (o_frame_valid) fv_count++;
  end

  task automatic hold(input logic [3:0] d, input logic [7:0] f, input int n);
    digit = d;
    font  = f;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2, input logic [7:0] f3);
    hold(4'b1110, f0, 8);
    hold(4'b1101, f1, 8);
    hold(4'b1011, f2, 8);
    hold(4'b0111, f3, 8);
    hold(4'hF, 8'hFF, 4);
  endtask

  task automatic expect_frame(input string tag, input int frames, input logic [15:0] bcd,
                              input logic [3:0] dp, input logic err);
    chk({tag, "_frames"}, 32'(fv_count), 32'(frames));
    chk({tag, "_bcd"}, 32'(o_bcd), 32'(bcd));
    chk({tag, "_dp"}, 32'(o_dp), 32'(dp));
    chk({tag, "_err"}, 32'(o_err), 32'(err));
  endtask

  initial begin
    rst_n = 1'b0;
    digit = 4'hF;
    font  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      digit = 4'($urandom);
      font  = 8'($urandom);
    end
    @(negedge clk);
    expect_frame("reset", 0, 16'h0, 4'h0, 1'b0);
    chk("reset_stale", 32'(o_stale), 32'd0);

    rst_n = 1'b1;
    hold(4'hF, 8'hFF, 25);
`ifdef FND_SCAN_TIMEOUT_EN
    chk("idle_stale", 32'(o_stale), 32'd1);
`else
    chk("idle_stale", 32'(o_stale), 32'd0);
`endif

    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    expect_frame("basic", 1, 16'h3210, 4'h0, 1'b0);
    chk("basic_stale", 32'(o_stale), 32'd0);

    scan(8'hC0, 8'h79, 8'hA4, 8'h8E);
    expect_frame("dp", 2, 16'hF210, 4'b0010, 1'b0);

    hold(4'b1110, 8'hC0, 3);
    hold(4'hF, 8'hFF, 2);
    hold(4'b1101, 8'hF9, 8);
    hold(4'b1011, 8'hA4, 8);
    hold(4'b0111, 8'hB0, 8);
    hold(4'hF, 8'hFF, 4);
    expect_frame("short", 2, 16'hF210, 4'b0010, 1'b0);
    hold(4'b1110, 8'hC0, 4);
    hold(4'hF, 8'hFF, 4);
    expect_frame("exact", 3, 16'h3210, 4'h0, 1'b0);

    scan(8'hC0, 8'hF9, 8'hFF, 8'hB0);
    expect_frame("badfont", 4, 16'h3010, 4'h0, 1'b1);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    expect_frame("clean1", 5, 16'h3210, 4'h0, 1'b0);

    hold(4'b1110, 8'hC0, 8);
    hold(4'b1101, 8'hF9, 8);
    hold(4'b1100, 8'hC0, 8);
    hold(4'b1011, 8'hA4, 8);
    hold(4'b0111, 8'hB0, 8);
    hold(4'hF, 8'hFF, 4);
    expect_frame("illegal", 6, 16'h3210, 4'h0, 1'b1);
    scan(8'h99, 8'h92, 8'h82, 8'hF8);
    expect_frame("clean2", 7, 16'h7654, 4'h0, 1'b0);

    hold(4'b1110, 8'h80, 8);
    hold(4'b1101, 8'h90, 8);
    rst_n = 1'b0;
    hold(4'hF, 8'hFF, 2);
    rst_n = 1'b1;
    hold(4'b1011, 8'hA4, 8);
    hold(4'b0111, 8'hB0, 8);
    hold(4'hF, 8'hFF, 4);
    expect_frame("midreset", 7, 16'h0, 4'h0, 1'b0);
    hold(4'b1110, 8'h88, 8);
    hold(4'b1101, 8'h83, 8);
    hold(4'hF, 8'hFF, 4);
    expect_frame("after_reset", 8, 16'h32BA, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
